// File: rtl/blit_pkg.sv
// blit_pkg: shared constants and types for the blitter command path.
package blit_pkg;
   localparam int CMD_W      = 96;
   localparam int FIFO_DEPTH = 256;
   typedef logic [CMD_W-1:0] blit_cmd_t;
   typedef logic [2:0]       req_idx_t;
   function automatic logic [7:0] pend_count(input logic g1, input logic g2);
      return {7'd0, g1} + {7'd0, g2};
   endfunction
endpackage

// File: rtl/rr_arbiter.sv
// rr_arbiter: combinational picker, round-robin after last_grant or fixed priority
// when strict is set; one-hot grant plus winner index.
module rr_arbiter
   import blit_pkg::*;
#(
   parameter int NUM_REQ = 2
) (
   input  logic [NUM_REQ-1:0] req,
   input  req_idx_t           last_grant,
   input  logic               enable,
   input  logic               strict,
   output logic [NUM_REQ-1:0] grant,
   output req_idx_t           winner,
   output logic               granted
);
   localparam int IW = NUM_REQ > 1 ? $clog2(NUM_REQ) : 1;
   int            base;
   int            sum;
   logic [IW-1:0] idx;
   always_comb begin
      grant   = '0;
      winner  = last_grant;
      granted = 1'b0;
      base    = (strict || int'(last_grant) >= NUM_REQ - 1) ? 0 : int'(last_grant) + 1;
      sum     = 0;
      idx     = '0;
      for (int k = 0; k < NUM_REQ; k++) begin
         sum = base + k >= NUM_REQ ? base + k - NUM_REQ : base + k;
         idx = IW'(sum);
         if (enable && !granted && req[idx]) begin
            granted    = 1'b1;
            grant[idx] = 1'b1;
            winner     = req_idx_t'(idx);
         end
      end
   end
endmodule

// File: rtl/blit_cmd_arbiter.sv
// blit_cmd_arbiter: shares the blitter command FIFO write port among requesters.
// Define BLIT_ARB_STRICT_EN for fixed priority (lowest index wins) instead of round-robin.
module blit_cmd_arbiter #(
   parameter int NUM_REQ = 2,
   parameter int CMD_W   = 96
) (
   input  logic                     clock,
   input  logic                     reset,
   input  logic [NUM_REQ-1:0]       req,
   input  logic [NUM_REQ*CMD_W-1:0] req_cmd,
   output logic [NUM_REQ-1:0]       ack,
   output logic [CMD_W-1:0]         cmd_in,
   output logic                     cmd_in_valid,
   input  logic [7:0]               fifo_slots_free,
   input  logic                     fifo_overflow,
   output logic [2:0]               last_grant,
   output logic                     arb_error
);
   import blit_pkg::*;
`ifdef BLIT_ARB_STRICT_EN
   localparam logic STRICT = 1'b1;
`else
   localparam logic STRICT = 1'b0;
`endif
   logic             g1, g2, enable, granted;
   logic [7:0]       pend;
   req_idx_t         winner;
   logic [CMD_W-1:0] sel;
   assign pend   = pend_count(g1, g2);
   // The free count lags writes by three cycles, so the two newest grants are not yet in it
   assign enable = !reset && fifo_slots_free > pend;
   rr_arbiter #(.NUM_REQ(NUM_REQ)) u_rr (
      .req       (req),
      .last_grant(last_grant),
      .enable    (enable),
      .strict    (STRICT),
      .grant     (ack),
      .winner    (winner),
      .granted   (granted)
   );
   always_comb begin
      sel = '0;
      for (int i = 0; i < NUM_REQ; i++) sel = ack[i] ? req_cmd[i*CMD_W +: CMD_W] : sel;
   end
   always_ff @(posedge clock) begin
      if (reset) begin
         cmd_in       <= '0;
         cmd_in_valid <= 1'b0;
         last_grant   <= 3'(NUM_REQ - 1);
         g1           <= 1'b0;
         g2           <= 1'b0;
         arb_error    <= 1'b0;
      end else begin
         g1           <= granted;
         g2           <= g1;
         cmd_in_valid <= granted;
         if (granted) begin
            cmd_in     <= sel;
            last_grant <= winner;
         end
         if (fifo_overflow) arb_error <= 1'b1;
      end
   end
endmodule

// File: tb/tb_blit_cmd_arbiter.sv
// tb_blit_cmd_arbiter: directed checks of grant order, throttling, error capture and reset,
// plus a lagging FIFO model run for ordering and overflow safety.
module tb_blit_cmd_arbiter;
   localparam int NUM_REQ = 2;
   localparam int CMD_W   = 96;
   localparam int DEPTH   = 8;
   localparam int NCMD    = 150;
`ifdef BLIT_ARB_STRICT_EN
   localparam bit STRICT = 1'b1;
`else
   localparam bit STRICT = 1'b0;
`endif
   localparam logic [95:0] A5 = {12{8'hA5}};
   logic                     clock = 1'b0;
   logic                     reset = 1'b1;
   logic [NUM_REQ-1:0]       req = '0;
   logic [NUM_REQ*CMD_W-1:0] req_cmd = '0;
   logic [NUM_REQ-1:0]       ack;
   logic [CMD_W-1:0]         cmd_in;
   logic                     cmd_in_valid;
   logic [7:0]               fifo_slots_free = 8'd255;
   logic                     fifo_overflow = 1'b0;
   logic [2:0]               last_grant;
   logic                     arb_error;
   int                       total = 0;
   int                       bad = 0;
   always #5 clock = ~clock;
   blit_cmd_arbiter #(.NUM_REQ(NUM_REQ), .CMD_W(CMD_W)) dut (
      .clock          (clock),
      .reset          (reset),
      .req            (req),
      .req_cmd        (req_cmd),
      .ack            (ack),
      .cmd_in         (cmd_in),
      .cmd_in_valid   (cmd_in_valid),
      .fifo_slots_free(fifo_slots_free),
      .fifo_overflow  (fifo_overflow),
      .last_grant     (last_grant),
      .arb_error      (arb_error)
   );
   task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask
   task automatic step;
      @(posedge clock);
      #1;
   endtask
   initial begin
      logic [1:0] exp3 [3];
      logic [1:0] exp1 [4];
      int         cnt, ncnt, written, order_err, ovf, id, s;
      int         seq [2];
      int         exps [2];
      logic       rd, ovf_now;
      logic [7:0] nslots;
      logic [1:0] acks;
      // reset state, with requests present to show ack is held low
      req     = 2'b11;
      req_cmd = {A5, A5};
      repeat (3) step;
      @(negedge clock);
      check("rst_ack", ack, 2'b00);
      check("rst_valid", cmd_in_valid, 1'b0);
      check("rst_cmd", cmd_in, 96'd0);
      check("rst_last", last_grant, 3'd1);
      check("rst_err", arb_error, 1'b0);
      step;
      reset = 1'b0;
      req   = 2'b00;
      // single command from requester 1
      req_cmd = {A5, 96'd0};
      req     = 2'b10;
      @(negedge clock);
      check("one_ack", ack, 2'b10);
      step;
      req = 2'b00;
      @(negedge clock);
      check("one_valid", cmd_in_valid, 1'b1);
      check("one_cmd", cmd_in, A5);
      check("one_last", last_grant, 3'd1);
      step;
      @(negedge clock);
      check("one_valid_drop", cmd_in_valid, 1'b0);
      check("one_cmd_hold", cmd_in, A5);
      step;
      // both requesting, plenty of room
      req = 2'b11;
      for (int k = 0; k < 6; k++) begin
         @(negedge clock);
         check($sformatf("rr_ack%0d", k), ack, STRICT ? 2'b01 : (k % 2 == 0 ? 2'b01 : 2'b10));
         step;
      end
      req = 2'b00;
      repeat (3) step;
      // free count stuck at 2
      exp3[0] = 2'b01;
      exp3[1] = STRICT ? 2'b01 : 2'b10;
      exp3[2] = 2'b00;
      fifo_slots_free = 8'd2;
      req = 2'b11;
      for (int k = 0; k < 3; k++) begin
         @(negedge clock);
         check($sformatf("s2_ack%0d", k), ack, exp3[k]);
         step;
      end
      req = 2'b00;
      fifo_slots_free = 8'd0;
      repeat (3) step;
      req = 2'b11;
      for (int k = 0; k < 3; k++) begin
         @(negedge clock);
         check($sformatf("s0_ack%0d", k), ack, 2'b00);
         step;
      end
      req = 2'b00;
      fifo_slots_free = 8'd1;
      repeat (3) step;
      // one slot: grant, then wait for it to show up in the count
      exp1[0] = 2'b01;
      exp1[1] = 2'b00;
      exp1[2] = 2'b00;
      exp1[3] = STRICT ? 2'b01 : 2'b10;
      req = 2'b11;
      for (int k = 0; k < 4; k++) begin
         @(negedge clock);
         check($sformatf("s1_ack%0d", k), ack, exp1[k]);
         step;
      end
      req = 2'b00;
      fifo_slots_free = 8'd255;
      repeat (3) step;
      // overflow capture
      fifo_overflow = 1'b1;
      @(negedge clock);
      check("ovf_same", arb_error, 1'b0);
      step;
      fifo_overflow = 1'b0;
      @(negedge clock);
      check("ovf_next", arb_error, 1'b1);
      repeat (5) step;
      @(negedge clock);
      check("ovf_sticky", arb_error, 1'b1);
      step;
      // reset right after a grant
      req = 2'b01;
      @(negedge clock);
      check("rg_ack", ack, 2'b01);
      step;
      reset = 1'b1;
      req   = 2'b00;
      @(negedge clock);
      check("rg_inflight", cmd_in_valid, 1'b1);
      step;
      @(negedge clock);
      check("rg_valid", cmd_in_valid, 1'b0);
      check("rg_last", last_grant, 3'd1);
      check("rg_err", arb_error, 1'b0);
      step;
      reset = 1'b0;
      req   = 2'b11;
      @(negedge clock);
      check("rg_first", ack, 2'b01);
      step;
      req = 2'b00;
      repeat (3) step;
      // lagging FIFO model with random reads
      cnt = 0;
      written = 0;
      order_err = 0;
      ovf = 0;
      seq[0] = 0;
      seq[1] = 0;
      exps[0] = 0;
      exps[1] = 0;
      fifo_slots_free = 8'(DEPTH);
      repeat (3) step;
      for (int i = 0; i < 2; i++) req_cmd[i*CMD_W +: CMD_W] = {8'(i), 72'd0, 16'(seq[i])};
      req = 2'b11;
      for (int cyc = 0; cyc < 3000 && written < 2 * NCMD; cyc++) begin
         @(negedge clock);
         rd      = cnt > 0 && $urandom_range(0, 1) == 1;
         ovf_now = 1'b0;
         if (cmd_in_valid) begin
            id = int'(cmd_in[95:88]);
            s  = int'(cmd_in[15:0]);
            if (id > 1 || s != exps[id]) order_err++;
            else exps[id]++;
            written++;
            if (cnt == DEPTH && !rd) begin
               ovf++;
               ovf_now = 1'b1;
            end
         end
         nslots = 8'(DEPTH - cnt);
         ncnt   = cnt + ((cmd_in_valid && !ovf_now) ? 1 : 0) - (rd ? 1 : 0);
         acks   = ack;
         step;
         cnt = ncnt;
         fifo_slots_free = nslots;
         fifo_overflow = ovf_now;
         for (int i = 0; i < 2; i++) begin
            if (acks[i]) seq[i]++;
            req_cmd[i*CMD_W +: CMD_W] = {8'(i), 72'd0, 16'(seq[i])};
            req[i] = seq[i] < NCMD;
         end
      end
      fifo_overflow = 1'b0;
      check("m_written", written, 2 * NCMD);
      check("m_order", order_err, 0);
      check("m_ovf", ovf, 0);
      check("m_seq0", exps[0], NCMD);
      check("m_seq1", exps[1], NCMD);
      @(negedge clock);
      check("m_err", arb_error, 1'b0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
